hazard_scoreboard: RTL and testbench

Parametrised hazard-tracking unit for the in-order pipeline. It sits beside the issue stage and replaces the fixed stall-count scheme. It tracks every in-flight destination register through a DEPTH-entry slot shift register, plus a busy bitmap for variable-latency mul/div operations. From this state it produces the issue stall, per-operand forwarding selects, and a saturating stall-cycle performance counter. Branch/jump-taken flush suppresses insertion of the issuing instruction.

---
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight destinations through a slot
// shift register plus a busy bitmap for long ops; drives stall, issue and forwarding.
module hazard_scoreboard #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CW         = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     id_valid,
  input  logic [AW-1:0]            id_rs1,
  input  logic [AW-1:0]            id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_we,
  input  logic                     id_load,
  input  logic                     id_long,
  input  logic                     flush,
  input  logic                     long_done,
  input  logic [AW-1:0]            long_rd,
  output logic                     stall,
  output logic                     issue_fire,
  output logic [$clog2(DEPTH)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH)-1:0] fwd_sel2,
  output logic [CW-1:0]            stall_cnt
);

  localparam int unsigned SW = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          is_load;
  } slot_t;

  typedef struct packed {
    logic          hit;
    logic          ready;
    logic [SW-1:0] idx;
  } prod_t;

  slot_t [DEPTH-1:0] slots_q, slots_d;
  logic  [NREG-1:0]  busy_q, busy_d;
  logic  [CW-1:0]    stall_cnt_q, stall_cnt_d;

  prod_t p1, p2;
  logic  raw_haz, long_haz, hazard;

  // Youngest (lowest slot index) valid entry writing rs is the producer.
  function automatic prod_t find_producer(input logic [AW-1:0]   rs,
                                          input logic            use_rs,
                                          input slot_t [DEPTH-1:0] slots);
    prod_t p;
    p = '0;
    if (use_rs && (rs != '0)) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (slots[k].valid && (slots[k].rd == rs)) begin
          p.hit   = 1'b1;
          p.idx   = SW'(k);
          p.ready = slots[k].is_load ? (k >= int'(LOAD_READY)) : (k >= 1);
        end
      end
    end
    return p;
  endfunction

  // Hazard detection and issue/forwarding decisions
  always_comb begin
    p1       = find_producer(id_rs1, id_use_rs1, slots_q);
    p2       = find_producer(id_rs2, id_use_rs2, slots_q);
    raw_haz  = (p1.hit & ~p1.ready) | (p2.hit & ~p2.ready);
    long_haz = (id_use_rs1 & busy_q[id_rs1])
             | (id_use_rs2 & busy_q[id_rs2])
             | (id_we & busy_q[id_rd])
             | (id_long & (|busy_q));
    hazard     = raw_haz | long_haz;
    stall      = id_valid & hazard & ~flush;
    issue_fire = id_valid & ~hazard & ~flush;
    fwd_sel1   = '0;
    fwd_sel2   = '0;
    if (id_valid && !stall) begin
      if (p1.hit && p1.ready) fwd_sel1 = p1.idx;
      if (p2.hit && p2.ready) fwd_sel2 = p2.idx;
    end
  end

  // Next state: slot shift, busy bitmap, saturating stall counter
  always_comb begin
    slots_d     = '0;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;

    if (issue_fire && id_we && (id_rd != '0) && !id_long) begin
      slots_d[0].valid   = 1'b1;
      slots_d[0].rd      = id_rd;
      slots_d[0].is_load = id_load;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      slots_d[k] = slots_q[k-1];
    end

    // Set is applied after clear so a same-register collision keeps the bit set.
    if (long_done) busy_d[long_rd] = 1'b0;
    if (issue_fire && id_long && id_we && (id_rd != '0)) busy_d[id_rd] = 1'b1;

    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slots_q     <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic against a per-register issue-time reference model.
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LR    = 2;
  localparam int CW    = 32;
  localparam int SW    = $clog2(DEPTH);
  localparam int NONE  = -100000;

  logic          clk;
  logic          nrst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_we, id_load, id_long, flush, long_done;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, long_rd;
  logic          stall, issue_fire;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LR), .CW(CW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .id_long(id_long),
    .flush(flush), .long_done(long_done), .long_rd(long_rd),
    .stall(stall), .issue_fire(issue_fire),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  // Reference state: cycle each register was last issued by a tracked writer.
  int     t_cyc;
  int     last_s [NREG];
  bit     last_ld[NREG];
  bit     busy_m [NREG];
  longint cnt_m;
  longint obs_stall, obs_fire, obs_f1, obs_f2, obs_cnt;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t_cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      last_s[i]  = NONE;
      last_ld[i] = 1'b0;
      busy_m[i]  = 1'b0;
    end
    cnt_m = 0;
  endtask

  // An instruction issued in cycle s sits in slot (t - s - 1) during cycle t.
  task automatic model_operand(input logic [AW-1:0] rs, input logic u,
                               output bit haz, output int sel);
    int age;
    haz = 1'b0;
    sel = 0;
    if (u && rs != 0 && last_s[rs] != NONE) begin
      age = t_cyc - last_s[rs] - 1;
      if (age >= 0 && age < DEPTH) begin
        if (age >= (last_ld[rs] ? LR : 1)) sel = age;
        else haz = 1'b1;
      end
    end
  endtask

  function automatic bit any_busy();
    for (int i = 0; i < NREG; i++) if (busy_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit lg, input bit fl);
    id_valid = v;   id_rs1 = AW'(r1); id_use_rs1 = u1; id_rs2 = AW'(r2); id_use_rs2 = u2;
    id_rd = AW'(rd); id_we = we; id_load = ld; id_long = lg; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    long_done = 1'b0;
    long_rd   = '0;
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit h1, h2, lh, haz, e_stall, e_fire;
    int s1, s2;
    #4;
    model_operand(id_rs1, id_use_rs1, h1, s1);
    model_operand(id_rs2, id_use_rs2, h2, s2);
    lh = (id_use_rs1 && busy_m[id_rs1]) || (id_use_rs2 && busy_m[id_rs2]) ||
         (id_we && busy_m[id_rd]) || (id_long && any_busy());
    haz     = h1 | h2 | lh;
    e_stall = id_valid & haz & ~flush;
    e_fire  = id_valid & ~haz & ~flush;
    if (!id_valid || e_stall) begin
      s1 = 0;
      s2 = 0;
    end
    check_eq("stall", longint'(stall), longint'(e_stall));
    check_eq("issue_fire", longint'(issue_fire), longint'(e_fire));
    check_eq("fwd_sel1", longint'(fwd_sel1), longint'(s1));
    check_eq("fwd_sel2", longint'(fwd_sel2), longint'(s2));
    check_eq("stall_cnt", longint'(stall_cnt), cnt_m);
    obs_stall = longint'(stall);   obs_fire = longint'(issue_fire);
    obs_f1 = longint'(fwd_sel1);   obs_f2 = longint'(fwd_sel2);
    obs_cnt = longint'(stall_cnt);
    @(posedge clk);
    if (!nrst) begin
      model_reset();
    end else begin
      if (e_fire && id_we && id_rd != 0 && !id_long) begin
        last_s[id_rd]  = t_cyc;
        last_ld[id_rd] = id_load;
      end
      if (long_done) busy_m[long_rd] = 1'b0;
      if (e_fire && id_long && id_we && id_rd != 0) busy_m[id_rd] = 1'b1;
      if (e_stall && cnt_m < ((64'd1 << CW) - 1)) cnt_m++;
    end
    t_cyc++;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) step();
  endtask

  longint c0;

  initial begin
    t_cyc = 0;
    nrst  = 1'b0;
    idle();
    model_reset();
    #3;
    step();
    check_eq("rst_stall", obs_stall, 0);
    check_eq("rst_cnt", obs_cnt, 0);
    #1 nrst = 1'b1;

    // ALU-to-use: one stall cycle, then forward from slot 1
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step();
    check_eq("alu_fire", obs_fire, 1);
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); step();
    check_eq("alu_stall_c1", obs_stall, 1);
    step();
    check_eq("alu_stall_c2", obs_stall, 0);
    check_eq("alu_fwd1", obs_f1, 1);
    check_eq("alu_fwd2", obs_f2, 0);
    check_eq("alu_cnt", obs_cnt, 1);
    drain();

    // Load-to-use: LR stall cycles, then forward from slot LR
    drive(1, 1, 1, 2, 1, 6, 1, 1, 0, 0); step();
    drive(1, 3, 1, 6, 1, 8, 1, 0, 0, 0); step();
    c0 = obs_cnt;
    check_eq("ld_stall_c1", obs_stall, 1);
    step();
    check_eq("ld_stall_c2", obs_stall, 1);
    step();
    check_eq("ld_stall_c3", obs_stall, 0);
    check_eq("ld_fwd2", obs_f2, 2);
    check_eq("ld_cnt_delta", obs_cnt - c0, 2);
    drain();

    // Long op: dependent holds until the cycle after long_done
    drive(1, 1, 1, 2, 1, 7, 1, 0, 1, 0); step();
    check_eq("mul_fire", obs_fire, 1);
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
    repeat (5) begin
      step();
      check_eq("mul_dep_hold", obs_stall, 1);
    end
    long_done = 1'b1; long_rd = 5'd7; step();
    check_eq("mul_done_cycle", obs_stall, 1);
    long_done = 1'b0; step();
    check_eq("mul_release", obs_stall, 0);
    check_eq("mul_release_fire", obs_fire, 1);
    drain();

    // x0 destination is never tracked
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0); step();
    check_eq("x0_stall", obs_stall, 0);
    check_eq("x0_fwd1", obs_f1, 0);
    drain();

    // Flush with pending hazard inserts a bubble; older slot keeps moving
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 11, 1, 0, 0, 1); step();
    check_eq("flush_stall", obs_stall, 0);
    check_eq("flush_fire", obs_fire, 0);
    drive(1, 11, 1, 5, 1, 12, 1, 0, 0, 0); step();
    check_eq("flush_bubble_stall", obs_stall, 0);
    check_eq("flush_bubble_fwd1", obs_f1, 0);
    check_eq("flush_older_fwd2", obs_f2, 1);
    drain();

    // Mid-cycle reset drops busy bits and slots at once
    drive(1, 1, 1, 2, 1, 9, 1, 0, 1, 0); step();
    drive(1, 9, 1, 0, 0, 4, 1, 0, 0, 0); step();
    check_eq("rst_pre_stall", obs_stall, 1);
    for (int r = 1; r <= 3; r++) begin
      drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0); step();
    end
    #2 nrst = 1'b0;
    model_reset();
    idle();
    step();
    check_eq("midrst_cnt", obs_cnt, 0);
    #2 nrst = 1'b1;
    drive(1, 9, 1, 1, 1, 4, 1, 0, 0, 0); step();
    check_eq("midrst_x9_stall", obs_stall, 0);
    check_eq("midrst_fwd2", obs_f2, 0);
    drain();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit lg;
      lg = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 7), $urandom_range(0, 5) != 0,
            !lg && ($urandom_range(0, 3) == 0), lg,
            $urandom_range(0, 9) == 0);
      long_done = ($urandom_range(0, 3) == 0);
      long_rd   = AW'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
